pll_lock_supervisor: RTL

- Consumes the PLL's extlock output and drives the PLL reset input: the controlling end of the PLL lock/reset handshake.
- Runs entirely on the free-running 24 MHz refclk, so it works while clk0_out is unstable.
- Qualifies lock for a stable interval before releasing the system reset, and retries the PLL on lock timeout.
- Detects lock loss, reports it, and enters a sticky fail state after repeated timeouts.

---
 rtl/pll_lock_supervisor.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Controls the PLL lock/reset handshake from the free-running reference clock.
// The PLL is pulsed into reset and given a bounded window to lock. Lock must
// then hold for a qualification interval before the downstream reset is
// released. Lock loss while running is reported and triggers a fresh bring-up.
// Repeated lock timeouts park the block in a terminal fail state that only
// reset can clear.
//
// Ports:
//   refclk       in   free-running reference clock, all logic on rising edge
//   reset        in   asynchronous active-high reset
//   extlock      in   PLL lock indication, asynchronous to refclk
//   pll_reset    out  PLL reset, high only while pulsing the PLL
//   sys_reset    out  downstream reset, low only while running
//   ready        out  high only while running
//   lock_lost    out  one-cycle pulse when lock drops while running
//   fail         out  sticky terminal failure indication
//   attempt_cnt  out  lock timeouts in the current bring-up sequence
//   loss_cnt     out  saturating count of lock-loss events since reset
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 24,
    parameter int LOCK_TIMEOUT_CYCLES = 240000,
    parameter int LOCK_STABLE_CYCLES  = 2400,
    parameter int MAX_ATTEMPTS        = 3,
    parameter int CNT_W               = 18
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       extlock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic       fail,
    output logic [1:0] attempt_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_QUALIFY   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]       ATTEMPT_LIMIT = 2'(MAX_ATTEMPTS);

    // Saturating increment for the 2-bit attempt counter.
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        if (v == 2'd3) begin
            sat_inc2 = 2'd3;
        end else begin
            sat_inc2 = v + 2'd1;
        end
    endfunction

    // Saturating increment for the 8-bit loss counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'd255) begin
            sat_inc8 = 8'd255;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_attempt;
    logic [7:0]       r_loss;
    logic             r_pll_reset;
    logic             r_sys_reset;
    logic             r_ready;
    logic             r_lock_lost;
    logic             r_fail;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_attempt_next;
    logic [1:0]       w_attempt_inc;
    logic [7:0]       w_loss_next;
    logic             w_lock_lost_next;
    logic             w_lock_s;

    assign w_lock_s      = r_sync2;
    assign w_attempt_inc = sat_inc2(r_attempt);

    // Two-flop synchronizer bringing extlock into the refclk domain.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= extlock;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state, shared counter and status counter decisions.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_attempt_next   = r_attempt;
        w_loss_next      = r_loss;
        w_lock_lost_next = 1'b0;
        case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_cnt_next   = CNT_ZERO;
                    w_state_next = ST_WAIT_LOCK;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested first so it wins over a coincident timeout.
                if (w_lock_s) begin
                    w_cnt_next   = CNT_ZERO;
                    w_state_next = ST_QUALIFY;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_attempt_next = w_attempt_inc;
                    w_cnt_next     = CNT_ZERO;
                    if (w_attempt_inc == ATTEMPT_LIMIT) begin
                        w_state_next = ST_FAIL;
                    end else begin
                        w_state_next = ST_PLL_RST;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_QUALIFY: begin
                // Any low sample drops back to waiting with a fresh window.
                if (!w_lock_s) begin
                    w_cnt_next   = CNT_ZERO;
                    w_state_next = ST_WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_cnt_next     = CNT_ZERO;
                    w_attempt_next = 2'd0;
                    w_state_next   = ST_RUN;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_lock_lost_next = 1'b1;
                    w_loss_next      = sat_inc8(r_loss);
                    w_cnt_next       = CNT_ZERO;
                    w_state_next     = ST_PLL_RST;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_FAIL: begin
                w_state_next = ST_FAIL;
            end
            default: begin
                w_cnt_next   = CNT_ZERO;
                w_state_next = ST_PLL_RST;
            end
        endcase
    end

    // State register, counters and output flops; outputs are decoded from the
    // next state so they change on the same edge as the state register.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_PLL_RST;
            r_cnt       <= CNT_ZERO;
            r_attempt   <= 2'd0;
            r_loss      <= 8'd0;
            r_pll_reset <= 1'b1;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_attempt   <= w_attempt_next;
            r_loss      <= w_loss_next;
            r_pll_reset <= (w_state_next == ST_PLL_RST);
            r_sys_reset <= (w_state_next != ST_RUN);
            r_ready     <= (w_state_next == ST_RUN);
            r_lock_lost <= w_lock_lost_next;
            r_fail      <= (w_state_next == ST_FAIL);
        end
    end

    assign pll_reset   = r_pll_reset;
    assign sys_reset   = r_sys_reset;
    assign ready       = r_ready;
    assign lock_lost   = r_lock_lost;
    assign fail        = r_fail;
    assign attempt_cnt = r_attempt;
    assign loss_cnt    = r_loss;

endmodule
